// File: rtl/seg_ctrl_pkg.sv
// Shared opcodes, FSM state type and status-byte layout for segment_cmd_controller.
package seg_ctrl_pkg;

  localparam logic [7:0] OP_WRITE_SEG   = 8'h01;
  localparam logic [7:0] OP_SET_BLINK   = 8'h02;
  localparam logic [7:0] OP_READ_STATUS = 8'h03;

  typedef enum logic {
    IDLE     = 1'b0,
    GET_DATA = 1'b1
  } state_t;

  // Status byte layout; blink code occupies bits [3:0]
  localparam int ST_ERR   = 7;
  localparam int ST_ABORT = 6;
  localparam int ST_BUSY  = 5;
  localparam int ST_PHASE = 4;

  function automatic logic [7:0] status_byte(input logic       err,
                                             input logic       abort,
                                             input logic       phase,
                                             input logic       busy,
                                             input logic [3:0] code);
    logic [7:0] s;
    s           = {4'h0, code};
    s[ST_ERR]   = err;
    s[ST_ABORT] = abort;
    s[ST_PHASE] = phase;
    s[ST_BUSY]  = busy;
    return s;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running prescaler plus tick counter; phase toggles every blink_code ticks
// and is held high while blink_code is zero. restart re-arms count and phase.
module blink_timer #(
  parameter int BLINK_DIV_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] blink_code,
  input  logic       restart,
  output logic       phase
);

  logic [BLINK_DIV_W-1:0] r_prescaler;
  logic [3:0]             r_count;
  logic                   r_phase;
  logic                   w_tick;

  // Tick on the cycle the prescaler wraps back to zero
  assign w_tick = &r_prescaler;
  assign phase  = r_phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prescaler <= '0;
      r_count     <= 4'd0;
      r_phase     <= 1'b1;
    end else begin
      r_prescaler <= r_prescaler + BLINK_DIV_W'(1);
      if (restart || (blink_code == 4'd0)) begin
        r_count <= 4'd0;
        r_phase <= 1'b1;
      end else if (w_tick) begin
        if (r_count == (blink_code - 4'd1)) begin
          r_count <= 4'd0;
          r_phase <= ~r_phase;
        end else begin
          r_count <= r_count + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/segment_cmd_controller.sv
// SPI command sequencer driving a blinking 7-segment register and returning a status byte.
// Define SEG_ACTIVE_LOW_EN for common-anode displays (seg_out inverted, 0xFF when blank).
module segment_cmd_controller
  import seg_ctrl_pkg::*;
#(
  parameter int BLINK_DIV_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       cs_active,
  output logic       tx_load,
  output logic [7:0] tx_data,
  output logic [7:0] seg_out,
  output logic       busy
);

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [7:0] SEG_POL = 8'hFF;
`else
  localparam logic [7:0] SEG_POL = 8'h00;
`endif

  state_t     r_state;
  logic [7:0] r_opcode;
  logic [7:0] r_seg_reg;
  logic [3:0] r_blink_code;
  logic       r_err;
  logic       r_abort;
  logic       r_tx_load;
  logic [7:0] r_tx_data;
  logic [7:0] r_seg_out;
  logic       r_busy;

  logic       w_phase;
  logic       w_frame_byte;
  logic       w_exec;
  logic       w_set_seg;
  logic       w_restart;
  logic [7:0] w_seg_nxt;
  logic [7:0] w_seg_vis;

  assign w_frame_byte = rx_valid && cs_active;
  assign w_exec       = (r_state == GET_DATA) && w_frame_byte;
  assign w_set_seg    = w_exec && (r_opcode == OP_WRITE_SEG);
  assign w_restart    = w_exec && (r_opcode == OP_SET_BLINK);
  // Use the incoming data byte so seg_out follows the write by one cycle
  assign w_seg_nxt    = w_set_seg ? rx_data : r_seg_reg;
  assign w_seg_vis    = w_phase ? w_seg_nxt : 8'h00;

  blink_timer #(
    .BLINK_DIV_W(BLINK_DIV_W)
  ) u_blink_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .blink_code(r_blink_code),
    .restart   (w_restart),
    .phase     (w_phase)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_opcode     <= 8'h00;
      r_seg_reg    <= 8'h00;
      r_blink_code <= 4'd0;
      r_err        <= 1'b0;
      r_abort      <= 1'b0;
      r_tx_load    <= 1'b0;
      r_tx_data    <= 8'h00;
      r_seg_out    <= SEG_POL;
      r_busy       <= 1'b0;
    end else begin
      r_tx_load <= 1'b0;
      r_seg_out <= w_seg_vis ^ SEG_POL;
      case (r_state)
        IDLE: begin
          if (w_frame_byte) begin
            if ((rx_data == OP_WRITE_SEG) || (rx_data == OP_SET_BLINK)) begin
              r_opcode <= rx_data;
              r_state  <= GET_DATA;
              r_busy   <= 1'b1;
            end else if (rx_data == OP_READ_STATUS) begin
              r_tx_load <= 1'b1;
              r_tx_data <= status_byte(r_err, r_abort, w_phase, r_busy, r_blink_code);
              r_err     <= 1'b0;
              r_abort   <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        GET_DATA: begin
          if (!cs_active) begin
            r_abort <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (rx_valid) begin
            if (w_set_seg) r_seg_reg <= rx_data;
            if (w_restart) r_blink_code <= rx_data[3:0];
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign tx_load = r_tx_load;
  assign tx_data = r_tx_data;
  assign seg_out = r_seg_out;
  assign busy    = r_busy;

endmodule
